// File: rtl/stopwatch_ctrl.sv
// Stopwatch control: button sync/debounce, run/lap/pause FSM,
// count-enable gating, clear pulse and lap latch.
module stopwatch_ctrl #(
  parameter int N               = 12,
  parameter int MAX_COUNT       = 999,
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic         clk100MHz,
  input  logic         rst,
  input  logic         tick_100hz,
  input  logic         btn_start,
  input  logic         btn_stop,
  input  logic         btn_lap,
  input  logic         btn_clr,
  input  logic [N-1:0] counter_value,
  output logic         cnt_en,
  output logic         cnt_clr,
  output logic [N-1:0] disp_value,
  output logic [N-1:0] lap_value,
  output logic         running,
  output logic         ovf
);

  localparam int CW =
    (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] DB_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [N-1:0]  MAX_V   = N'(MAX_COUNT);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    LAP,
    PAUSED
  } state_e;

  // bit 0 start, 1 stop, 2 lap, 3 clr
  logic [3:0]    btn_raw;
  logic [3:0]    sync1_q;
  logic [3:0]    sync2_q;
  logic [3:0]    db_q;
  logic [3:0]    db_prev_q;
  logic [CW-1:0] dbc_q [4];
  logic [3:0]    press;

  assign btn_raw = {btn_clr, btn_lap, btn_stop, btn_start};
  assign press   = db_q & ~db_prev_q;

  always_ff @(posedge clk100MHz or posedge rst) begin
    if (rst) begin
      sync1_q   <= '0;
      sync2_q   <= '0;
      db_q      <= '0;
      db_prev_q <= '0;
      for (int i = 0; i < 4; i++) begin
        dbc_q[i] <= '0;
      end
    end else begin
      sync1_q   <= btn_raw;
      sync2_q   <= sync1_q;
      db_prev_q <= db_q;
      for (int i = 0; i < 4; i++) begin
        if (sync2_q[i] == db_q[i]) begin
          dbc_q[i] <= '0;
        end else if (dbc_q[i] == DB_LAST) begin
          db_q[i]  <= sync2_q[i];
          dbc_q[i] <= '0;
        end else begin
          dbc_q[i] <= dbc_q[i] + 1'b1;
        end
      end
    end
  end

  logic p_clr;
  logic p_stop;
  logic p_start;
  logic p_lap;

  // One winner per cycle: clr > stop > start > lap
  always_comb begin
    p_clr   = 1'b0;
    p_stop  = 1'b0;
    p_start = 1'b0;
    p_lap   = 1'b0;
    priority case (1'b1)
      press[3]: p_clr   = 1'b1;
      press[1]: p_stop  = 1'b1;
      press[0]: p_start = 1'b1;
      press[2]: p_lap   = 1'b1;
      default: ;
    endcase
  end

  state_e       state_q;
  logic         cnt_clr_q;
  logic         ovf_q;
  logic         hold_q;
  logic [N-1:0] lap_q;
  logic         counting;
  logic         at_max;
  logic         sat;

  assign counting = (state_q == RUN) || (state_q == LAP);
  assign at_max   = (counter_value == MAX_V);
  assign sat      = tick_100hz & counting & at_max;

  always_ff @(posedge clk100MHz or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_clr_q <= 1'b0;
      ovf_q     <= 1'b0;
      hold_q    <= 1'b0;
      lap_q     <= '0;
    end else begin
      cnt_clr_q <= 1'b0;
      if (p_clr) begin
        state_q   <= IDLE;
        cnt_clr_q <= 1'b1;
        ovf_q     <= 1'b0;
        hold_q    <= 1'b0;
        lap_q     <= '0;
      end else if (sat) begin
        state_q <= PAUSED;
        ovf_q   <= 1'b1;
        hold_q  <= 1'b0;
      end else begin
        unique case (state_q)
          IDLE: begin
            if (p_start) state_q <= RUN;
          end
          RUN: begin
            if (p_stop) begin
              state_q <= PAUSED;
            end else if (p_lap) begin
              state_q <= LAP;
              lap_q   <= counter_value;
              hold_q  <= 1'b1;
            end
          end
          LAP: begin
            if (p_stop) begin
              state_q <= PAUSED;
              hold_q  <= 1'b0;
            end else if (p_lap) begin
              state_q <= RUN;
              hold_q  <= 1'b0;
            end
          end
          PAUSED: begin
            if (p_start && !ovf_q) state_q <= RUN;
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign cnt_en     = tick_100hz & counting & ~at_max;
  assign cnt_clr    = cnt_clr_q;
  assign lap_value  = lap_q;
  assign disp_value = hold_q ? lap_q : counter_value;
  assign running    = counting;
  assign ovf        = ovf_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed bench for stopwatch_ctrl with a short debounce period.
module tb_stopwatch_ctrl;

  localparam int N = 12;

  logic         clk;
  logic         rst;
  logic         tick;
  logic         b_start;
  logic         b_stop;
  logic         b_lap;
  logic         b_clr;
  logic [N-1:0] cval;
  logic         cnt_en;
  logic         cnt_clr;
  logic [N-1:0] disp_value;
  logic [N-1:0] lap_value;
  logic         running;
  logic         ovf;

  int compared;
  int mismatched;
  int en_seen;
  int clr_seen;

  stopwatch_ctrl #(
    .N(N),
    .MAX_COUNT(999),
    .DEBOUNCE_CYCLES(4)
  ) dut (
    .clk100MHz(clk),
    .rst(rst),
    .tick_100hz(tick),
    .btn_start(b_start),
    .btn_stop(b_stop),
    .btn_lap(b_lap),
    .btn_clr(b_clr),
    .counter_value(cval),
    .cnt_en(cnt_en),
    .cnt_clr(cnt_clr),
    .disp_value(disp_value),
    .lap_value(lap_value),
    .running(running),
    .ovf(ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (cnt_en === 1'b1) en_seen = en_seen + 1;
    if (cnt_clr === 1'b1) clr_seen = clr_seen + 1;
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // m: bit0 start, bit1 stop, bit2 lap, bit3 clr
  task automatic set_btns(input logic [3:0] m);
    {b_clr, b_lap, b_stop, b_start} = m;
  endtask

  task automatic press(input logic [3:0] m);
    set_btns(m);
    cyc(10);
    set_btns(4'b0000);
    cyc(8);
  endtask

  task automatic do_tick();
    tick = 1'b1;
    cyc(1);
    tick = 1'b0;
  endtask

  int e0;
  int c0;
  int n;

  initial begin
    compared   = 0;
    mismatched = 0;
    en_seen    = 0;
    clr_seen   = 0;
    rst  = 1'b1;
    tick = 1'b0;
    cval = '0;
    set_btns(4'b0000);
    cyc(3);
    rst = 1'b0;
    cyc(1);

    chk("rst_running", running, 0);
    chk("rst_disp", disp_value, 0);
    chk("rst_lap", lap_value, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_cnt_clr", cnt_clr, 0);
    repeat (5) do_tick();
    chk("idle_no_en", en_seen, 0);

    set_btns(4'b0001);
    cyc(3);
    set_btns(4'b0000);
    cyc(10);
    do_tick();
    chk("short_press_running", running, 0);
    chk("short_press_en", en_seen, 0);

    press(4'b0001);
    chk("start_running", running, 1);
    e0 = en_seen;
    repeat (3) do_tick();
    chk("run_3_ticks", en_seen - e0, 3);
    press(4'b0010);
    chk("stop_running", running, 0);
    e0 = en_seen;
    do_tick();
    chk("paused_no_en", en_seen - e0, 0);

    press(4'b0001);
    chk("resume_running", running, 1);
    cval = 12'd123;
    press(4'b0100);
    chk("lap_latch", lap_value, 123);
    cval = 12'd130;
    #1;
    chk("lap_disp_frozen", disp_value, 123);
    chk("lap_running", running, 1);
    e0 = en_seen;
    do_tick();
    chk("lap_counts", en_seen - e0, 1);
    press(4'b0100);
    chk("unlap_disp", disp_value, 130);
    chk("unlap_running", running, 1);
    chk("unlap_lap_kept", lap_value, 123);

    cval = 12'd999;
    tick = 1'b1;
    #1;
    chk("sat_no_en", cnt_en, 0);
    cyc(1);
    tick = 1'b0;
    chk("sat_running", running, 0);
    chk("sat_ovf", ovf, 1);
    chk("sat_disp", disp_value, 999);
    press(4'b0001);
    chk("sat_start_ignored", running, 0);
    c0 = clr_seen;
    press(4'b1000);
    chk("clr_pulse_once", clr_seen - c0, 1);
    chk("clr_ovf", ovf, 0);
    chk("clr_lap", lap_value, 0);
    chk("clr_running", running, 0);

    cval = 12'd5;
    press(4'b0001);
    press(4'b0010);
    chk("paused_again", running, 0);
    c0 = clr_seen;
    press(4'b1001);
    chk("clr_beats_start_pulse", clr_seen - c0, 1);
    chk("clr_beats_start_run", running, 0);

    press(4'b0001);
    chk("run_before_stoptick", running, 1);
    set_btns(4'b0010);
    cyc(6);
    tick = 1'b1;
    #1;
    chk("stop_tick_en", cnt_en, 1);
    cyc(1);
    tick = 1'b0;
    chk("stop_tick_paused", running, 0);
    set_btns(4'b0000);
    cyc(8);

    press(4'b0001);
    cval = 12'd200;
    press(4'b0100);
    chk("lap2_disp", disp_value, 200);
    cval = 12'd210;
    set_btns(4'b1000);
    cyc(3);
    rst = 1'b1;
    #1;
    chk("midrst_running", running, 0);
    chk("midrst_lap", lap_value, 0);
    chk("midrst_disp", disp_value, 210);
    chk("midrst_ovf", ovf, 0);
    chk("midrst_cnt_clr", cnt_clr, 0);
    cyc(2);
    rst = 1'b0;
    n = 0;
    while (cnt_clr !== 1'b1 && n < 20) begin
      cyc(1);
      n++;
    end
    chk("rst_full_debounce", (n >= 6 && n <= 8), 1);
    set_btns(4'b0000);
    cyc(8);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule
